// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath (fetch/decode/exec/mem/wb).
// Handshakes with shared instruction/data memory and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic             Zero,
  input  logic             mem_ack,
  output logic             imem_req,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             BR_En,
  output logic [2:0]       AluC,
  output logic             ALUSrc,
  output logic             EnR,
  output logic             EnW,
  output logic             Mux1,
  output logic             illegal,
  output logic             err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t            state;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_SLTI, OP_ANDI, OP_ORI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Sequencer state, latched opcode, memory wait counter and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      op_q     <= '0;
      retired  <= '0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            state <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          op_q  <= OpCode;
          state <= is_legal(OpCode) ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          if (op_q == OP_BEQ) begin
            retired <= retired + CNT_W'(1);
            state   <= S_FETCH;
          end else if (op_q == OP_LW || op_q == OP_SW) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op_q == OP_SW) begin
              retired <= retired + CNT_W'(1);
              state   <= S_FETCH;
            end else begin
              state <= S_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired <= retired + CNT_W'(1);
          state   <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from state and latched opcode; forced low during reset
  always_comb begin
    imem_req = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    BR_En    = 1'b0;
    AluC     = 3'b000;
    ALUSrc   = 1'b0;
    EnR      = 1'b0;
    EnW      = 1'b0;
    Mux1     = 1'b0;
    illegal  = 1'b0;
    state_o  = 3'(state);
    if (!rst) begin
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
        case (op_q)
          OP_R:                 begin AluC = 3'b000; ALUSrc = 1'b0; RegDst = 1'b1; end
          OP_ADDI, OP_LW, OP_SW: begin AluC = 3'b010; ALUSrc = 1'b1; end
          OP_SLTI:              begin AluC = 3'b100; ALUSrc = 1'b1; end
          OP_ANDI:              begin AluC = 3'b011; ALUSrc = 1'b1; end
          OP_ORI:               begin AluC = 3'b101; ALUSrc = 1'b1; end
          OP_BEQ:               begin AluC = 3'b001; end
          default:              begin AluC = 3'b000; end
        endcase
      end
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = mem_ack;
          PCWrite  = mem_ack;
        end
        S_DECODE: illegal = !is_legal(OpCode);
        S_EXEC: begin
          if (op_q == OP_BEQ) begin
            PCWrite = Zero;
            PCSrc   = Zero;
          end
        end
        S_MEM: begin
          EnR = (op_q == OP_LW);
          EnW = (op_q == OP_SW);
        end
        S_WB: begin
          BR_En = 1'b1;
          Mux1  = (op_q != OP_LW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: an instruction-level model expands each instruction into
// its expected per-cycle control trace, compared cycle by cycle against the DUT.
module tb_multicycle_ctrl_fsm;
  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int unsigned CNT_W       = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       OpCode;
  logic             Zero;
  logic             mem_ack;
  logic             imem_req, PCWrite, PCSrc, IRWrite, RegDst, BR_En;
  logic [2:0]       AluC;
  logic             ALUSrc, EnR, EnW, Mux1, illegal, err;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Zero(Zero), .mem_ack(mem_ack),
    .imem_req(imem_req), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .RegDst(RegDst), .BR_En(BR_En), .AluC(AluC), .ALUSrc(ALUSrc), .EnR(EnR),
    .EnW(EnW), .Mux1(Mux1), .illegal(illegal), .err(err), .state_o(state_o),
    .retired(retired)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {imem_req, PCWrite, PCSrc, IRWrite, RegDst, BR_En, AluC, ALUSrc,
                EnR, EnW, Mux1, illegal, err, state_o};

  typedef struct packed {
    logic        ack;
    logic [17:0] exp;
  } step_t;

  step_t            q[$];
  int unsigned      checks = 0;
  int unsigned      passes = 0;
  logic [CNT_W-1:0] exp_ret = '0;
  logic [5:0]       cur_op;
  logic             cur_zero;
  logic [5:0]       legal_ops[8] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011,
                                     6'b000100, 6'b001010, 6'b001100, 6'b001101};

  function automatic logic [17:0] vec(input logic req, pcw, pcs, irw, rd, br,
                                      input logic [2:0] alu, input logic as, enr, enw,
                                      m1, ill, e, input logic [2:0] st);
    return {req, pcw, pcs, irw, rd, br, alu, as, enr, enw, m1, ill, e, st};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Per-opcode ALU control, ALU source and destination select: {AluC, ALUSrc, RegDst}
  function automatic logic [4:0] alu_ctl(input logic [5:0] op);
    case (op)
      6'b000000: return {3'b000, 1'b0, 1'b1};
      6'b001010: return {3'b100, 1'b1, 1'b0};
      6'b001100: return {3'b011, 1'b1, 1'b0};
      6'b001101: return {3'b101, 1'b1, 1'b0};
      6'b000100: return {3'b001, 1'b0, 1'b0};
      default:   return {3'b010, 1'b1, 1'b0};
    endcase
  endfunction

  function automatic void push(input logic ack, input logic [17:0] v);
    step_t s;
    s.ack = ack;
    s.exp = v;
    q.push_back(s);
  endfunction

  // Expand one instruction into its expected cycle trace; mw >= MEM_TIMEOUT means no data ack
  task automatic build(input logic [5:0] op, input logic z, input int fw, input int mw);
    logic [4:0] c;
    logic is_lw, is_sw;
    c     = alu_ctl(op);
    is_lw = (op == 6'b100011);
    is_sw = (op == 6'b101011);
    cur_op   = op;
    cur_zero = z;
    q.delete();
    for (int i = 0; i < fw; i++) push(1'b0, vec(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'd0));
    push(1'b1, vec(1, 1, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'd0));
    push(1'($urandom), vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, !is_legal(op), 0, 3'd1));
    if (!is_legal(op)) return;
    if (op == 6'b000100) begin
      push(1'($urandom), vec(0, z, z, 0, c[0], 0, c[4:2], c[1], 0, 0, 0, 0, 0, 3'd2));
      exp_ret = exp_ret + CNT_W'(1);
      return;
    end
    push(1'($urandom), vec(0, 0, 0, 0, c[0], 0, c[4:2], c[1], 0, 0, 0, 0, 0, 3'd2));
    if (is_lw || is_sw) begin
      if (mw >= int'(MEM_TIMEOUT)) begin
        for (int i = 0; i < int'(MEM_TIMEOUT); i++)
          push(1'b0, vec(0, 0, 0, 0, c[0], 0, c[4:2], c[1], is_lw, is_sw, 0, 0, 0, 3'd3));
        for (int i = 0; i < 3; i++)
          push(1'($urandom), vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 3'd7));
        return;
      end
      for (int i = 0; i < mw; i++)
        push(1'b0, vec(0, 0, 0, 0, c[0], 0, c[4:2], c[1], is_lw, is_sw, 0, 0, 0, 3'd3));
      push(1'b1, vec(0, 0, 0, 0, c[0], 0, c[4:2], c[1], is_lw, is_sw, 0, 0, 0, 3'd3));
      if (is_sw) begin
        exp_ret = exp_ret + CNT_W'(1);
        return;
      end
    end
    push(1'($urandom), vec(0, 0, 0, 0, c[0], 1, c[4:2], c[1], 0, 0, !is_lw, 0, 0, 3'd4));
    exp_ret = exp_ret + CNT_W'(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Drive each queued cycle just after the falling edge, compare, then advance one cycle
  task automatic run_steps(input string tag, input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s       = q.pop_front();
      mem_ack = s.ack;
      OpCode  = (s.exp[2:0] == 3'd1) ? cur_op : 6'($urandom);
      Zero    = (s.exp[2:0] == 3'd2) ? cur_zero : 1'($urandom);
      #1 chk($sformatf("%s_cyc%0d", tag, i), 32'(obs), 32'(s.exp));
      @(negedge clk);
    end
  endtask

  task automatic instr(input string tag, input logic [5:0] op, input logic z,
                       input int fw, input int mw);
    build(op, z, fw, mw);
    run_steps(tag, 1000);
    #1 chk({tag, "_retired"}, 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    logic [5:0] op;
    rst = 1'b1; mem_ack = 1'b0; OpCode = '0; Zero = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk("reset_outputs", 32'(obs), 32'(vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'd0)));
    chk("reset_retired", 32'(retired), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    instr("addi",     6'b001000, 1'b0, 0, 0);
    instr("lw_wait2", 6'b100011, 1'b0, 0, 2);
    instr("beq_z1",   6'b000100, 1'b1, 0, 0);
    instr("beq_z0",   6'b000100, 1'b0, 1, 0);
    instr("illegal",  6'b111111, 1'b0, 0, 0);
    instr("sw",       6'b101011, 1'b0, 2, 0);
    instr("r_type",   6'b000000, 1'b0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      instr($sformatf("rand%0d", k), op, 1'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
    end

    // Data memory never acknowledges a store: controller halts with err set
    instr("sw_timeout", 6'b101011, 1'b0, 0, int'(MEM_TIMEOUT));
    mem_ack = 1'b0;
    rst = 1'b1;
    #1 chk("halt_in_rst", 32'(obs), 32'(vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 3'd7)));
    @(negedge clk);
    rst = 1'b0;
    exp_ret = '0;
    #1 chk("halt_recover", 32'(obs), 32'(vec(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'd0)));
    chk("halt_recover_retired", 32'(retired), 32'(exp_ret));

    instr("addi_after", 6'b001000, 1'b0, 0, 0);

    // Reset during a store's memory phase: write enable drops immediately, nothing retires
    build(6'b101011, 1'b0, 0, 3);
    run_steps("sw_rst", 3);
    mem_ack = 1'b0;
    rst = 1'b1;
    #1 chk("sw_rst_mem", 32'(obs), 32'(vec(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'd3)));
    chk("sw_rst_enw", 32'(EnW), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_ret = '0;
    #1 chk("sw_rst_fetch", 32'(obs), 32'(vec(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'd0)));
    chk("sw_rst_retired", 32'(retired), 32'(exp_ret));
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
